// File: rtl/id_stage.sv
// id_stage: instruction-decode pipeline stage following if_stage.
// Latches the fetched PC/instruction through a valid/allowin handshake,
// resolves LoongArch control transfers against register-file operands,
// redirects fetch on a taken branch (squashing the fall-through fetch) and
// forwards the instruction plus link-register write info towards EX.
module id_stage (
    input  logic        clk,
    input  logic        reset,

    // IF -> ID handshake
    input  logic        fs_to_ds_valid,
    input  logic [31:0] fs_pc,
    input  logic [31:0] fs_inst,
    output logic        ds_allowin,

    // ID -> EX handshake
    input  logic        es_allowin,
    output logic        ds_to_es_valid,
    output logic [31:0] ds_pc,
    output logic [31:0] ds_inst,

    // register-file read ports
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,

    // redirect back to IF
    output logic        br_taken,
    output logic [31:0] br_target,

    // link-register write info for EX
    output logic        ds_link_we,
    output logic [4:0]  ds_link_addr,
    output logic [31:0] ds_link_value
);

    localparam logic [5:0] OP_JIRL = 6'h13;
    localparam logic [5:0] OP_B    = 6'h14;
    localparam logic [5:0] OP_BL   = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h16;
    localparam logic [5:0] OP_BNE  = 6'h17;
    localparam logic [5:0] OP_BLT  = 6'h18;
    localparam logic [5:0] OP_BGE  = 6'h19;
    localparam logic [5:0] OP_BLTU = 6'h1a;
    localparam logic [5:0] OP_BGEU = 6'h1b;

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_pc_q,    ds_pc_d;
    logic [31:0] ds_inst_q,  ds_inst_d;

    logic        ds_ready_go;
    logic [5:0]  op;
    logic [4:0]  rj, rd;
    logic [31:0] offs16, offs26;

    logic        is_jirl, is_b, is_bl, is_cond;
    logic        cond_hit;

    // This stage never stalls on its own; EX back-pressure is the only hold.
    assign ds_ready_go    = 1'b1;
    assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid_q && ds_ready_go;

    assign ds_pc   = ds_pc_q;
    assign ds_inst = ds_inst_q;

    assign op = ds_inst_q[31:26];
    assign rj = ds_inst_q[9:5];
    assign rd = ds_inst_q[4:0];

    assign rf_raddr1 = rj;
    assign rf_raddr2 = rd;

    // Word offsets: 16-bit field for conditional/jirl, split 26-bit field for b/bl.
    assign offs16 = {{14{ds_inst_q[25]}}, ds_inst_q[25:10], 2'b00};
    assign offs26 = {{4{ds_inst_q[9]}}, ds_inst_q[9:0], ds_inst_q[25:10], 2'b00};

    // Opcode classification of the instruction held in ID.
    always_comb begin
        is_jirl = 1'b0;
        is_b    = 1'b0;
        is_bl   = 1'b0;
        is_cond = 1'b0;
        case (op)
            OP_JIRL: is_jirl = 1'b1;
            OP_B:    is_b    = 1'b1;
            OP_BL:   is_bl   = 1'b1;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: is_cond = 1'b1;
            default: ;
        endcase
    end

    // Branch condition: unconditional transfers always hit, others compare rj vs rd.
    always_comb begin
        cond_hit = 1'b0;
        case (op)
            OP_JIRL, OP_B, OP_BL: cond_hit = 1'b1;
            OP_BEQ:  cond_hit = (rf_rdata1 == rf_rdata2);
            OP_BNE:  cond_hit = (rf_rdata1 != rf_rdata2);
            OP_BLT:  cond_hit = ($signed(rf_rdata1) <  $signed(rf_rdata2));
            OP_BGE:  cond_hit = ($signed(rf_rdata1) >= $signed(rf_rdata2));
            OP_BLTU: cond_hit = (rf_rdata1 <  rf_rdata2);
            OP_BGEU: cond_hit = (rf_rdata1 >= rf_rdata2);
            default: cond_hit = 1'b0;
        endcase
    end

    // Redirect address; only meaningful while br_taken is high.
    always_comb begin
        br_target = ds_pc_q + offs16;
        if (is_jirl) begin
            br_target = rf_rdata1 + offs16;
        end else if (is_b || is_bl) begin
            br_target = ds_pc_q + offs26;
        end
    end

    // Redirect only in the cycle the branch actually leaves for EX, so it
    // fires exactly once; suppressed while reset is asserted.
    assign br_taken = ds_valid_q && es_allowin && cond_hit && !reset;

    // Link write: bl always targets r1; jirl to r0 is a plain jump.
    assign ds_link_we    = ds_valid_q && (is_bl || (is_jirl && (rd != 5'd0)));
    assign ds_link_addr  = is_bl ? 5'd1 : rd;
    assign ds_link_value = ds_pc_q + 32'd4;

    // Next-state: load on allowin, dropping the fall-through fetch of a taken branch.
    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_pc_d    = ds_pc_q;
        ds_inst_d  = ds_inst_q;
        if (ds_allowin) begin
            ds_valid_d = fs_to_ds_valid && !br_taken;
            ds_pc_d    = fs_pc;
            ds_inst_d  = fs_inst;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            ds_pc_q    <= 32'd0;
            ds_inst_q  <= 32'd0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_pc_q    <= ds_pc_d;
            ds_inst_q  <= ds_inst_d;
        end
    end

    logic unused_ok;
    assign unused_ok = is_cond;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed branch scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc, fs_inst;
    logic        ds_allowin;
    logic        es_allowin;
    logic        ds_to_es_valid;
    logic [31:0] ds_pc, ds_inst;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_link_we;
    logic [4:0]  ds_link_addr;
    logic [31:0] ds_link_value;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP = 32'h02800000;

    // model state
    logic        m_valid;
    logic [31:0] m_pc, m_inst;
    logic        n_valid;
    logic [31:0] n_pc, n_inst;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
        .ds_allowin(ds_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc), .ds_inst(ds_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .br_taken(br_taken), .br_target(br_target),
        .ds_link_we(ds_link_we), .ds_link_addr(ds_link_addr),
        .ds_link_value(ds_link_value)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fsv, input logic [31:0] pc,
                         input logic [31:0] inst, input logic esa,
                         input logic [31:0] r1, input logic [31:0] r2);
        reset          = rst;
        fs_to_ds_valid = fsv;
        fs_pc          = pc;
        fs_inst        = inst;
        es_allowin     = esa;
        rf_rdata1      = r1;
        rf_rdata2      = r2;
    endtask

    // Reference: what the held instruction does, from the ISA rules.
    task automatic model_eval(output logic tk, output logic [31:0] tgt,
                              output logic lwe, output logic [4:0] laddr);
        int unsigned op;
        int          off16, off26;
        logic signed [15:0] f16;
        logic signed [25:0] f26;
        logic cond;
        op    = int'(m_inst[31:26]);
        f16   = m_inst[25:10];
        f26   = {m_inst[9:0], m_inst[25:10]};
        off16 = int'(f16) * 4;
        off26 = int'(f26) * 4;
        cond  = 1'b0;
        tgt   = m_pc + off16;
        case (op)
            'h13: begin cond = 1'b1; tgt = rf_rdata1 + off16; end
            'h14, 'h15: begin cond = 1'b1; tgt = m_pc + off26; end
            'h16: cond = (rf_rdata1 == rf_rdata2);
            'h17: cond = (rf_rdata1 != rf_rdata2);
            'h18: cond = (int'(rf_rdata1) <  int'(rf_rdata2));
            'h19: cond = (int'(rf_rdata1) >= int'(rf_rdata2));
            'h1a: cond = (rf_rdata1 <  rf_rdata2);
            'h1b: cond = (rf_rdata1 >= rf_rdata2);
            default: cond = 1'b0;
        endcase
        tk    = m_valid && es_allowin && cond && !reset;
        lwe   = m_valid && ((op == 'h15) || (op == 'h13 && m_inst[4:0] != 0));
        laddr = (op == 'h15) ? 5'd1 : m_inst[4:0];
    endtask

    // Sample at negedge, compare against the model, and compute next model state.
    task automatic check_cycle();
        logic tk, lwe, alw;
        logic [31:0] tgt;
        logic [4:0] laddr;
        @(negedge clk);
        model_eval(tk, tgt, lwe, laddr);
        alw = !m_valid || es_allowin;
        chk("allowin",   ds_allowin, alw);
        chk("to_es_vld", ds_to_es_valid, m_valid);
        chk("ds_pc",     ds_pc, m_pc);
        chk("ds_inst",   ds_inst, m_inst);
        chk("raddr1",    rf_raddr1, m_inst[9:5]);
        chk("raddr2",    rf_raddr2, m_inst[4:0]);
        chk("br_taken",  br_taken, tk);
        if (tk) chk("br_target", br_target, tgt);
        chk("link_we",   ds_link_we, lwe);
        if (lwe) begin
            chk("link_addr", ds_link_addr, laddr);
            chk("link_val",  ds_link_value, m_pc + 4);
        end
        n_valid = m_valid; n_pc = m_pc; n_inst = m_inst;
        if (reset) begin
            n_valid = 1'b0; n_pc = '0; n_inst = '0;
        end else if (alw) begin
            n_valid = fs_to_ds_valid && !tk;
            n_pc    = fs_pc;
            n_inst  = fs_inst;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_valid = n_valid; m_pc = n_pc; m_inst = n_inst;
    endtask

    task automatic tick(input logic rst, input logic fsv, input logic [31:0] pc,
                        input logic [31:0] inst, input logic esa,
                        input logic [31:0] r1, input logic [31:0] r2);
        drive(rst, fsv, pc, inst, esa, r1, r2);
        check_cycle();
        advance();
    endtask

    // Offer a branch, resolve it next cycle, then check squash/proceed of the fall-through.
    task automatic br_pair(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic exp_tk, input logic [31:0] exp_tgt,
                           input logic exp_lwe, input logic [4:0] exp_la);
        tick(0, 1, pc, inst, 1, 0, 0);
        drive(0, 1, pc + 4, NOP, 1, r1, r2);
        check_cycle();
        chk({tag, "_tk"}, br_taken, exp_tk);
        if (exp_tk) chk({tag, "_tgt"}, br_target, exp_tgt);
        chk({tag, "_lwe"}, ds_link_we, exp_lwe);
        if (exp_lwe) begin
            chk({tag, "_la"}, ds_link_addr, exp_la);
            chk({tag, "_lv"}, ds_link_value, pc + 4);
        end
        advance();
        drive(0, 0, pc + 8, NOP, 1, 0, 0);
        check_cycle();
        chk({tag, "_next_vld"}, ds_to_es_valid, !exp_tk);
        if (!exp_tk) chk({tag, "_next_pc"}, ds_pc, pc + 4);
        advance();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int unsigned sel;
        w   = $urandom;
        sel = $urandom_range(0, 11);
        if (sel <= 8) w[31:26] = 6'(6'h13 + sel);
        return w;
    endfunction

    initial begin
        m_valid = 0; m_pc = 0; m_inst = 0;
        drive(1, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // reset state
        drive(0, 0, 32'h1c000000, NOP, 1, 0, 0);
        check_cycle();
        chk("rst_allowin", ds_allowin, 1'b1);
        chk("rst_vld",     ds_to_es_valid, 1'b0);
        chk("rst_br",      br_taken, 1'b0);
        chk("rst_lwe",     ds_link_we, 1'b0);
        advance();

        // sequential stream
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 32'h1c000000 + 32'(i * 4), NOP, 1, 0, 0);
            check_cycle();
            if (i > 0) begin
                chk("seq_vld", ds_to_es_valid, 1'b1);
                chk("seq_pc",  ds_pc, 32'h1c000000 + 32'((i - 1) * 4));
            end
            chk("seq_br", br_taken, 1'b0);
            advance();
        end
        tick(0, 0, 0, NOP, 1, 0, 0);

        br_pair("beq_t",  32'h1c000000, 32'h58000822, 5, 5, 1, 32'h1c000008, 0, 0);
        br_pair("beq_n",  32'h1c000000, 32'h58000822, 5, 6, 0, 0, 0, 0);
        br_pair("b",      32'h1c000010, 32'h50010000, 0, 0, 1, 32'h1c000110, 0, 0);
        br_pair("bl",     32'h1c000020, 32'h57ffffff, 0, 0, 1, 32'h1c00001c, 1, 5'd1);
        br_pair("jirl",   32'h1c000030, 32'h4c000020, 32'h1c000400, 0, 1, 32'h1c000400, 0, 0);
        br_pair("jirl_w", 32'h1c000040, 32'h4ffffc23, 32'h2, 0, 1, 32'hfffffffe, 1, 5'd3);
        br_pair("blt",    32'h1c000050, 32'h60000422, 32'hffffffff, 1, 1, 32'h1c000054, 0, 0);
        br_pair("bltu",   32'h1c000060, 32'h68000422, 32'hffffffff, 1, 0, 0, 0, 0);
        br_pair("bge",    32'h1c000070, 32'h64000422, 32'hffffffff, 1, 0, 0, 0, 0);
        br_pair("bgeu",   32'h1c000080, 32'h6c000422, 32'hffffffff, 1, 1, 32'h1c000084, 0, 0);

        // back-pressure with a taken beq held in ID
        tick(0, 1, 32'h1c000100, 32'h58000822, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h1c000104, NOP, 0, 5, 5);
            check_cycle();
            chk("bp_br",    br_taken, 1'b0);
            chk("bp_allow", ds_allowin, 1'b0);
            chk("bp_pc",    ds_pc, 32'h1c000100);
            advance();
        end
        drive(0, 1, 32'h1c000104, NOP, 1, 5, 5);
        check_cycle();
        chk("bp_rel_br",  br_taken, 1'b1);
        chk("bp_rel_tgt", br_target, 32'h1c000108);
        advance();
        drive(0, 1, 32'h1c000108, NOP, 1, 5, 5);
        check_cycle();
        chk("bp_pulse_once", br_taken, 1'b0);
        advance();

        // reset in the middle of a hold
        tick(0, 1, 32'h1c000200, 32'h58000822, 1, 0, 0);
        tick(0, 1, 32'h1c000204, NOP, 0, 5, 5);
        drive(1, 1, 32'h1c000204, NOP, 0, 5, 5);
        check_cycle();
        chk("rsthold_br", br_taken, 1'b0);
        advance();
        drive(0, 0, 32'h1c000208, NOP, 1, 5, 5);
        check_cycle();
        chk("rsthold_vld", ds_to_es_valid, 1'b0);
        chk("rsthold_br2", br_taken, 1'b0);
        advance();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
                 {$urandom_range(0, 32'h3fffffff), 2'b00}, rand_inst(),
                 ($urandom_range(0, 3) != 0), a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
